// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass and load-use bubbling
// Optional stats counters (bubble_cnt, flush_cnt) are enabled by defining ID_EX_STATS_EN.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [4:0]        id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              wb_we,
    input  logic [4:0]        wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic              ex_rd_we,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [XLEN-1:0]   ex_imm,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic [CTRL_W-1:0] ex_ctrl
`ifdef ID_EX_STATS_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    logic [XLEN-1:0] byp_a;
    logic [XLEN-1:0] byp_b;
    logic            haz;
    logic            rs1_hit;
    logic            rs2_hit;

    // Register file writes at the edge, so ID must see the WB value this cycle.
    assign byp_a = (wb_we && wb_addr != 5'd0 && wb_addr == id_rs1) ? wb_data : id_rdata1;
    assign byp_b = (wb_we && wb_addr != 5'd0 && wb_addr == id_rs2) ? wb_data : id_rdata2;

    assign rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign haz      = id_valid && ex_valid && ex_is_load && ex_rd_we && (ex_rd != 5'd0)
                      && (rs1_hit || rs2_hit);
    assign stall_id = !ex_flush && (ex_hold || haz);

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_rd_we   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_pc      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= '0;
        end else if (ex_flush || (!ex_hold && haz)) begin
            // Bubble: only the qualifying fields clear; datapath fields keep their value.
            ex_valid   <= 1'b0;
            ex_rd_we   <= 1'b0;
            ex_is_load <= 1'b0;
            ex_ctrl    <= '0;
        end else if (!ex_hold) begin
            ex_valid   <= id_valid;
            ex_rd_we   <= id_valid && id_rd_we;
            ex_is_load <= id_valid && id_is_load;
            ex_ctrl    <= id_valid ? id_ctrl : '0;
            ex_pc      <= id_pc;
            ex_a       <= byp_a;
            ex_b       <= byp_b;
            ex_imm     <= id_imm;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
        end
    end

`ifdef ID_EX_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (ex_flush)
                flush_cnt <= flush_cnt + 32'd1;
            else if (!ex_hold && haz)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
